pes_elevator: RTL and testbench
===============================

# pes_elevator

Single-car elevator controller for an 8-floor shaft with one-hot floor encoding. It accepts a target floor and an initial car position, and moves the car one floor per clock toward the target. It reports travel direction and arrival, and halts motion while a door-timeout or overweight condition is present. It sits between the floor-request/sensor logic and the car drive and indicator outputs.

## Interface
- No parameters. Floor count is fixed at 8; floor bus width is fixed at 8 bits, one-hot, bit 0 = lowest floor.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `request_floor` in 8: target floor, one-hot; sampled every cycle.
- `in_current_floor` in 8: initial car position, one-hot; sampled only while `reset` is high.
- `over_time` in 1: door held open too long; blocks motion.
- `over_weight` in 1: car overloaded; blocks motion.
- `out_current_floor` out 8: registered car position, one-hot.
- `direction` out 1: registered; 1 = up, 0 = down.
- `complete` out 1: registered; car is at the requested floor.
- `door_alert` out 1: registered copy of `over_time`.
- `weight_alert` out 1: registered copy of `over_weight`.

## Operation
- Validity rule: a floor bus is valid when exactly one bit is set.
- Internal state register has four states: IDLE, UP, DOWN, HALT. The state is not exported. The design is a registered FSM plus a position shift register.
- **Reset** (`reset`=1 at an edge):
  - `out_current_floor` <= `in_current_floor` if that bus is valid, else 8'b00000001.
  - `direction`=0, `complete`=0, `door_alert`=0, `weight_alert`=0; state = IDLE.
- **Normal edge**, evaluated in priority order:
  1. `door_alert` <= `over_time` and `weight_alert` <= `over_weight`, unconditionally.
  2. If `over_weight` or `over_time` is 1: state = HALT and position holds. `direction` holds. `complete` <= (position == valid request).
  3. Else if `request_floor` is invalid: state = IDLE, position holds, `complete` <= 0, `direction` holds.
  4. Else compare position and request as unsigned 8-bit values (one-hot ordering equals floor ordering):
     - request > position: position <= position << 1, `direction` <= 1, state = UP.
     - request < position: position <= position >> 1, `direction` <= 0, state = DOWN.
     - equal: position holds, `direction` holds, state = IDLE.
  5. `complete` <= (next position == request). It therefore rises on the same edge as the final step.
- The car moves exactly one floor per unblocked cycle; it never skips floors and never overshoots.
- A request change mid-travel takes effect on the next edge. A reversal is immediate, with no dwell cycle.
- When alerts clear, motion resumes on the first edge with both inputs low. No restart delay.
- Position can never leave one-hot form: a shift occurs only toward a valid, different floor, so the bit never shifts out.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset takes effect at the edge where `reset` is sampled high. Outputs hold reset values until the first edge after deassertion.
- Travel latency is N unblocked edges for N floors of distance. `complete` is high after the Nth edge.
- Alert latency: `door_alert`/`weight_alert` follow their inputs with 1-cycle delay. Motion is blocked on the same edge the input is sampled high.
- `over_weight` and `over_time` both high: both alerts set, motion blocked. Neither has priority beyond that.
- Reset mid-travel: position reloads from `in_current_floor`, alerts clear, and travel restarts from that floor on the next unreset edge.

## Test plan
- Reset with `in_current_floor`=8'h80, `request_floor`=8'h01 -> after reset: `out_current_floor`=8'h80, `complete`=0, alerts 0. Then 8'h40, 8'h20 … 8'h01 on successive edges with `direction`=0; `complete`=1 on the 7th edge and it stays 1.
- Reset at 8'h01, request 8'h08 -> 3 edges of travel with `direction`=1 (8'h02, 8'h04, 8'h08); `complete`=1 on the 3rd edge.
- Mid-travel `over_time`=1 for 1 cycle -> position frozen for that edge, `door_alert`=1 for one cycle; travel resumes on the next edge with total latency +1.
- `over_weight`=1 for 2 cycles while moving -> `weight_alert`=1 for 2 cycles, position held 2 edges. Both alerts high together -> both alerts set, no motion.
- Invalid inputs: request 8'h03 -> position holds, `complete`=0. Reset with `in_current_floor`=8'h00 -> position 8'h01.
- Reset asserted mid-travel with `in_current_floor`=8'h10 -> position 8'h10 at the reset edge; alerts cleared; travel toward the request resumes after deassertion.

Source files
------------

// File: rtl/pes_elevator.sv
// pes_elevator: single-car controller for an 8-floor shaft.
// The car moves one floor per clock toward a one-hot target floor.
// Motion stops while a door-timeout or overweight condition is present.
//
// Ports:
//   clk               - clock; all state updates on its rising edge
//   reset             - synchronous, active-high; loads the car position
//   request_floor     - target floor, one-hot (bit 0 = lowest floor)
//   in_current_floor  - initial car position, one-hot; used only during reset
//   over_time         - door held open too long; blocks motion
//   over_weight       - car overloaded; blocks motion
//   out_current_floor - registered car position, one-hot
//   direction         - registered travel direction (1 = up, 0 = down)
//   complete          - registered; the car is at the requested floor
//   door_alert        - registered copy of over_time
//   weight_alert      - registered copy of over_weight
module pes_elevator (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] request_floor,
   input  logic [7:0] in_current_floor,
   input  logic       over_time,
   input  logic       over_weight,
   output logic [7:0] out_current_floor,
   output logic       direction,
   output logic       complete,
   output logic       door_alert,
   output logic       weight_alert
);

   typedef enum logic [1:0] {IDLE, UP, DOWN, HALT} state_t;

   state_t     state, state_nxt;
   logic [7:0] pos_nxt;
   logic       dir_nxt;
   logic       cmp_nxt;
   logic       req_valid;
   logic       blocked;

   // A floor bus is valid only when exactly one bit is set.
   function automatic logic is_onehot(input logic [7:0] b);
      return (b != 8'd0) && ((b & (b - 8'd1)) == 8'd0);
   endfunction

   assign req_valid = is_onehot(request_floor);
   assign blocked   = over_time | over_weight;

   always_comb begin
      state_nxt = state;
      pos_nxt   = out_current_floor;
      dir_nxt   = direction;
      cmp_nxt   = 1'b0;
      if (blocked) begin
         state_nxt = HALT;
         cmp_nxt   = req_valid && (out_current_floor == request_floor);
      end else if (!req_valid) begin
         state_nxt = IDLE;
      end else begin
         // With one-hot encoding, unsigned magnitude order matches floor order.
         if (request_floor > out_current_floor) begin
            pos_nxt   = out_current_floor << 1;
            dir_nxt   = 1'b1;
            state_nxt = UP;
         end else if (request_floor < out_current_floor) begin
            pos_nxt   = out_current_floor >> 1;
            dir_nxt   = 1'b0;
            state_nxt = DOWN;
         end else begin
            state_nxt = IDLE;
         end
         // Arrival is flagged on the same edge as the final step.
         cmp_nxt = (pos_nxt == request_floor);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_current_floor <= is_onehot(in_current_floor) ? in_current_floor : 8'b0000_0001;
         direction         <= 1'b0;
         complete          <= 1'b0;
         door_alert        <= 1'b0;
         weight_alert      <= 1'b0;
         state             <= IDLE;
      end else begin
         out_current_floor <= pos_nxt;
         direction         <= dir_nxt;
         complete          <= cmp_nxt;
         door_alert        <= over_time;
         weight_alert      <= over_weight;
         state             <= state_nxt;
      end
   end

endmodule

// File: tb/tb_pes_elevator.sv
// Testbench for pes_elevator: directed scenarios followed by random traffic,
// all compared against an integer-floor reference model.
module tb_pes_elevator;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] request_floor;
   logic [7:0] in_current_floor;
   logic       over_time;
   logic       over_weight;
   logic [7:0] out_current_floor;
   logic       direction;
   logic       complete;
   logic       door_alert;
   logic       weight_alert;

   int total = 0;
   int bad   = 0;

   // Reference model state: the car floor as an integer 0..7.
   int m_floor = 0;
   bit m_dir   = 1'b0;
   bit m_cmp   = 1'b0;
   bit m_da    = 1'b0;
   bit m_wa    = 1'b0;

   pes_elevator dut (
      .clk               (clk),
      .reset             (reset),
      .request_floor     (request_floor),
      .in_current_floor  (in_current_floor),
      .over_time         (over_time),
      .over_weight       (over_weight),
      .out_current_floor (out_current_floor),
      .direction         (direction),
      .complete          (complete),
      .door_alert        (door_alert),
      .weight_alert      (weight_alert)
   );

   always #5 clk = ~clk;

   function automatic bit valid_bus(input logic [7:0] b);
      return $countones(b) == 1;
   endfunction

   function automatic int floor_of(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         if (b[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, clock, then check outputs.
   task automatic step(input logic rst, input logic [7:0] init, input logic [7:0] req,
                       input logic ot, input logic ow);
      logic [7:0] exp_pos;
      int         tgt;
      reset            = rst;
      in_current_floor = init;
      request_floor    = req;
      over_time        = ot;
      over_weight      = ow;
      tgt = floor_of(req);
      if (rst) begin
         m_floor = valid_bus(init) ? floor_of(init) : 0;
         m_dir = 0; m_cmp = 0; m_da = 0; m_wa = 0;
      end else begin
         m_da = ot;
         m_wa = ow;
         if (ot || ow) begin
            m_cmp = valid_bus(req) && (tgt == m_floor);
         end else if (!valid_bus(req)) begin
            m_cmp = 0;
         end else begin
            if (tgt > m_floor) begin
               m_floor = m_floor + 1; m_dir = 1;
            end else if (tgt < m_floor) begin
               m_floor = m_floor - 1; m_dir = 0;
            end
            m_cmp = (tgt == m_floor);
         end
      end
      exp_pos = 8'h01 << m_floor;
      @(posedge clk);
      #1;
      chk("position",     out_current_floor, exp_pos);
      chk("direction",    {7'd0, direction},    {7'd0, m_dir});
      chk("complete",     {7'd0, complete},     {7'd0, m_cmp});
      chk("door_alert",   {7'd0, door_alert},   {7'd0, m_da});
      chk("weight_alert", {7'd0, weight_alert}, {7'd0, m_wa});
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] ini;
      reset = 1'b1; in_current_floor = 8'h00; request_floor = 8'h00;
      over_time = 1'b0; over_weight = 1'b0;

      // Descend from top floor to bottom floor.
      step(1, 8'h80, 8'h01, 0, 0);
      chk("reset_pos_80", out_current_floor, 8'h80);
      for (int i = 0; i < 7; i++) step(0, 8'h00, 8'h01, 0, 0);
      chk("descent_arrive", {out_current_floor[7:1], complete}, 8'h01);
      step(0, 8'h00, 8'h01, 0, 0);
      chk("complete_holds", {7'd0, complete}, 8'h01);

      // Ascend three floors.
      step(1, 8'h01, 8'h08, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h08, 0, 0);
      chk("ascent_arrive", out_current_floor, 8'h08);

      // Door timeout for one cycle mid-travel.
      step(1, 8'h01, 8'h80, 0, 0);
      step(0, 8'h00, 8'h80, 0, 0);
      step(0, 8'h00, 8'h80, 1, 0);
      chk("door_freeze", out_current_floor, 8'h02);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 8'h80, 0, 0);
      chk("door_resume", out_current_floor, 8'h80);

      // Overweight for two cycles, then both alerts together.
      step(1, 8'h80, 8'h01, 0, 0);
      step(0, 8'h00, 8'h01, 0, 0);
      step(0, 8'h00, 8'h01, 0, 1);
      step(0, 8'h00, 8'h01, 0, 1);
      chk("weight_hold", out_current_floor, 8'h40);
      step(0, 8'h00, 8'h01, 1, 1);
      step(0, 8'h00, 8'h01, 0, 0);
      chk("weight_resume", out_current_floor, 8'h20);

      // Invalid request and invalid initial floor.
      step(0, 8'h00, 8'h03, 0, 0);
      chk("invalid_req_hold", out_current_floor, 8'h20);
      step(1, 8'h00, 8'h80, 0, 0);
      chk("invalid_init", out_current_floor, 8'h01);

      // Reset mid-travel.
      step(0, 8'h00, 8'h80, 0, 0);
      step(0, 8'h00, 8'h80, 0, 0);
      step(1, 8'h10, 8'h80, 1, 1);
      chk("midtravel_reset", out_current_floor, 8'h10);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h80, 0, 0);
      chk("midtravel_arrive", out_current_floor, 8'h80);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) r = 8'($urandom());
         else r = 8'h01 << $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) ini = 8'($urandom());
         else ini = 8'h01 << $urandom_range(0, 7);
         step(($urandom_range(0, 39) == 0), ini, r,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) != 0) begin
            // Hold the request steady for a while so trips complete.
            for (int k = 0; k < int'($urandom_range(1, 6)); k++)
               step(0, ini, r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
